// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - drives one DSP48A1 slice through an N-term signed multiply-accumulate
module dsp_mac_sequencer #(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4,
  parameter int OPM_DLY  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a_in,
  input  logic [B_W-1:0]   b_in,
  output logic [A_W-1:0]   dsp_a,
  output logic [B_W-1:0]   dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  output logic             busy,
  output logic             res_valid,
  output logic [47:0]      res_data
);

  localparam int DCNT_W = $clog2(PIPE_LAT + 1);

  // OPMODE encodings: X=OPMODE[1:0] (01 = M), Z=OPMODE[3:2] (10 = P)
  localparam logic [7:0] OPM_FIRST = 8'h01;  // P = M
  localparam logic [7:0] OPM_ACC   = 8'h09;  // P = P + M
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // P = P

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LEN_W-1:0]        r_cnt;
  logic [LEN_W-1:0]        w_cnt_nxt;
  logic [DCNT_W-1:0]       r_dcnt;
  logic [DCNT_W-1:0]       w_dcnt_nxt;
  logic                    r_first;
  logic                    w_first_nxt;
  logic [47:0]             r_res_data;
  logic [47:0]             w_res_data_nxt;
  logic [OPM_DLY-1:0][7:0] r_opm;
  logic [7:0]              w_opm_in;
  logic                    w_beat;

  assign res_data   = r_res_data;
  assign dsp_opmode = r_opm[OPM_DLY-1];

  // State and job bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dcnt     <= '0;
      r_first    <= 1'b0;
      r_res_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_first    <= w_first_nxt;
      r_res_data <= w_res_data_nxt;
    end
  end

  // OPMODE delay line, stepped with the slice so each opmode stays paired with its operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opm <= '0;
    end else if (dsp_ce) begin
      r_opm[0] <= w_opm_in;
      for (int i = 1; i < OPM_DLY; i++) begin
        r_opm[i] <= r_opm[i-1];
      end
    end
  end

  // Next-state logic and slice control outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dcnt_nxt     = r_dcnt;
    w_first_nxt    = r_first;
    w_res_data_nxt = r_res_data;
    w_opm_in       = OPM_HOLD;
    w_beat         = 1'b0;
    in_ready       = 1'b0;
    busy           = 1'b0;
    res_valid      = 1'b0;
    dsp_ce         = 1'b0;
    dsp_a          = '0;
    dsp_b          = '0;
    // P/M sync reset tracks the async reset so the slice is clean after power-up
    dsp_rstp       = rst;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = len;
            w_first_nxt = 1'b1;
            dsp_rstp    = 1'b1;
          end else begin
            w_state_nxt    = S_RESULT;
            w_res_data_nxt = '0;
          end
        end
      end

      S_RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        // A bubble drops CE so the whole slice pipeline and the opmode line freeze together
        dsp_ce   = in_valid;
        dsp_a    = a_in;
        dsp_b    = b_in;
        w_opm_in = r_first ? OPM_FIRST : OPM_ACC;
        w_beat   = in_valid & ~abort;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_beat) begin
          w_first_nxt = 1'b0;
          w_cnt_nxt   = r_cnt - 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            w_state_nxt = S_DRAIN;
            w_dcnt_nxt  = DCNT_W'(PIPE_LAT);
          end
        end
      end

      S_DRAIN: begin
        busy     = 1'b1;
        dsp_ce   = 1'b1;
        w_opm_in = OPM_HOLD;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_dcnt == '0) begin
          w_res_data_nxt = dsp_p;
          w_state_nxt    = S_RESULT;
        end else begin
          w_dcnt_nxt = r_dcnt - 1'b1;
        end
      end

      S_RESULT: begin
        busy        = 1'b1;
        res_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - directed bench with a behavioural DSP48A1 slice model
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] a_in = '0;
  logic [17:0] b_in = '0;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce;
  logic        dsp_rstp;
  logic [47:0] dsp_p;
  logic        busy;
  logic        res_valid;
  logic [47:0] res_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rv_cnt = 0;
  int rv_cyc = 0;
  int ce_cnt = 0;
  int rv0 = 0;
  int ce0 = 0;
  int last_edge = 0;

  logic [17:0] ta [8];
  logic [17:0] tb_ [8];

  always #5 clk = ~clk;

  dsp_mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_rstp(dsp_rstp), .dsp_p(dsp_p), .busy(busy), .res_valid(res_valid),
    .res_data(res_data)
  );

  // Slice model: 3 CE stages to M, P updated on the 4th; opmode pins are registered once before the post-adder
  logic signed [35:0] prod36;
  logic [47:0] m0 = '0, m1 = '0, m2 = '0, p_reg = '0;
  logic [7:0]  opm_r = '0;
  assign prod36 = $signed(dsp_a) * $signed(dsp_b);
  assign dsp_p  = p_reg;

  always @(posedge clk) begin
    if (dsp_ce) begin
      m0    <= {{12{prod36[35]}}, prod36};
      m1    <= m0;
      m2    <= m1;
      opm_r <= dsp_opmode;
      p_reg <= ((opm_r[3:2] == 2'b10) ? p_reg : 48'd0) + ((opm_r[1:0] == 2'b01) ? m2 : 48'd0);
    end
    if (dsp_rstp) begin
      m2    <= '0;
      p_reg <= '0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (res_valid) begin
      rv_cnt = rv_cnt + 1;
      rv_cyc = cyc;
    end
    if (dsp_ce) ce_cnt = ce_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] l);
    rv0   = rv_cnt;
    ce0   = ce_cnt;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int bubble, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int k = 0; k < bubble; k++) begin
          in_valid = 1'b0;
          #1 check_eq({tag, "_bubble_ce"}, dsp_ce, 0);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      a_in = ta[i];
      b_in = tb_[i];
      #1 check_eq({tag, "_beat_ce"}, dsp_ce, 1);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    last_edge = cyc;
  endtask

  task automatic finish_job(input logic [47:0] exp, input int exp_ce, input string tag);
    repeat (10) @(posedge clk);
    #1;
    check_eq({tag, "_strobes"}, rv_cnt - rv0, 1);
    check_eq({tag, "_latency"}, rv_cyc - last_edge, 5);
    check_eq({tag, "_data"}, res_data, exp);
    check_eq({tag, "_ce_cycles"}, ce_cnt - ce0, exp_ce);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    // reset state
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_ce", dsp_ce, 0);
    check_eq("rst_opmode", dsp_opmode, 0);
    check_eq("rst_rstp", dsp_rstp, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 check_eq("post_rst_rstp", dsp_rstp, 0);

    // 1: 2*5 + 3*6 + 4*7 back to back
    ta[0] = 18'd2; ta[1] = 18'd3; ta[2] = 18'd4;
    tb_[0] = 18'd5; tb_[1] = 18'd6; tb_[2] = 18'd7;
    do_start(8'd3);
    check_eq("t1_in_ready", in_ready, 1);
    feed(3, 0, "t1");
    finish_job(48'd56, 8, "t1");

    // 4: abort after two beats; result register must hold 56
    ta[0] = 18'd9; ta[1] = 18'd9; tb_[0] = 18'd9; tb_[1] = 18'd9;
    do_start(8'd4);
    feed(2, 0, "t4");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("t4_busy_after_abort", busy, 0);
    check_eq("t4_ready_after_abort", in_ready, 0);
    repeat (8) @(posedge clk);
    #1;
    check_eq("t4_no_strobe", rv_cnt - rv0, 0);
    check_eq("t4_data_held", res_data, 48'd56);
    ta[0] = 18'h3FFFD; tb_[0] = 18'd7;
    do_start(8'd1);
    feed(1, 0, "t4b");
    finish_job(48'hFFFF_FFFF_FFEB, 6, "t4b");

    // 2: same dot product with two-cycle bubbles
    ta[0] = 18'd2; ta[1] = 18'd3; ta[2] = 18'd4;
    tb_[0] = 18'd5; tb_[1] = 18'd6; tb_[2] = 18'd7;
    do_start(8'd3);
    feed(3, 2, "t2");
    finish_job(48'd56, 8, "t2");

    // 3: zero-length job
    do_start(8'd0);
    check_eq("t3_res_valid", res_valid, 1);
    @(posedge clk); #1;
    check_eq("t3_strobe_len", res_valid, 0);
    check_eq("t3_data", res_data, 0);
    check_eq("t3_ce_never", ce_cnt - ce0, 0);
    check_eq("t3_strobes", rv_cnt - rv0, 1);

    // 5: async reset in DRAIN, then 1*1 + 1*1
    ta[0] = 18'd5; ta[1] = 18'd6; ta[2] = 18'd7;
    tb_[0] = 18'd5; tb_[1] = 18'd6; tb_[2] = 18'd7;
    do_start(8'd3);
    feed(3, 0, "t5");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_in_ready", in_ready, 0);
    check_eq("t5_res_valid", res_valid, 0);
    check_eq("t5_res_data", res_data, 0);
    check_eq("t5_dsp_a", dsp_a, 0);
    check_eq("t5_dsp_b", dsp_b, 0);
    check_eq("t5_ce", dsp_ce, 0);
    check_eq("t5_opmode", dsp_opmode, 0);
    check_eq("t5_rstp", dsp_rstp, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 check_eq("t5_no_strobe", rv_cnt - rv0, 0);
    ta[0] = 18'd1; ta[1] = 18'd1; tb_[0] = 18'd1; tb_[1] = 18'd1;
    do_start(8'd2);
    feed(2, 0, "t5b");
    finish_job(48'd2, 7, "t5b");

    // 6: start while busy and during RESULT is ignored; full-scale signed operands
    ta[0] = 18'h20000; tb_[0] = 18'h20000;
    do_start(8'd1);
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("t6_busy_run", busy, 1);
    feed(1, 0, "t6");
    repeat (5) @(posedge clk);
    #1;
    check_eq("t6_result_strobe", res_valid, 1);
    check_eq("t6_data", res_data, 48'h4_0000_0000);
    start = 1'b1; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("t6_start_in_result_ignored", busy, 0);
    repeat (8) @(posedge clk);
    #1;
    check_eq("t6_single_strobe", rv_cnt - rv0, 1);
    check_eq("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
